mic_level_meter: RTL and testbench
==================================

Name: mic_level_meter

Overview:
- Upstream feeder for the OLED volume-bar display stage. It converts raw 12-bit microphone samples into the 4-bit volume level (0..15) that the bar renderer draws.
- Tracks the peak sample over a fixed window of accepted samples, then quantises that peak into a level.
- Applies instant attack and one-step-per-window release so the bar falls smoothly.
- Also exports the latched raw peak for other display modes.

Parameters:
- WINDOW, 4000, accepted samples per measurement window (4000 samples = 0.2 s at 20 kHz); legal range 2..65535.
- BASE, 12'd2048, mic mid-scale; a peak at or below BASE maps to level 0.
- STEP_SHIFT, 7, level = (peak - BASE) >> STEP_SHIFT, saturated at 15.
- DECAY_EN, 1, 1 = release limited to -1 per window; 0 = level follows the new value directly.

Ports:
- clk  in  1  system clock (100 MHz); all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- sample_valid  in  1  one-cycle strobe; mic_in is valid in that cycle.
- mic_in  in  12  unsigned microphone sample.
- freeze  in  1  1 = hold level/peak outputs; accumulation continues.
- level  out  4  volume level for the bar renderer.
- peak  out  12  raw peak of the last completed window.
- level_valid  out  1  one-cycle pulse when level/peak are updated.

Behaviour:
- Reset (async assert, sync release):
  - level=0, peak=0, level_valid=0.
  - sample counter cnt=0, accumulator acc=0, FSM in ACCUM.
- FSM states: ACCUM, EVAL.
- ACCUM:
  - On sample_valid: acc <= max(acc, mic_in); cnt <= cnt+1.
  - When the accepted sample is the WINDOW-th (cnt==WINDOW-1), acc takes the max including that sample, cnt <= 0, and the FSM goes to EVAL.
  - Cycles without sample_valid change nothing.
- EVAL (exactly one cycle):
  - Compute new = 0 if acc <= BASE, else min(15, (acc-BASE) >> STEP_SHIFT). Arithmetic is 12-bit unsigned; the subtraction is only evaluated when acc > BASE, so there is no wrap.
  - If freeze=0:
    - peak <= acc.
    - level <= new if new >= level, or if DECAY_EN=0.
    - Otherwise level <= level-1.
    - level_valid=1 for this edge only.
  - If freeze=1: level, peak hold and level_valid stays 0; the window result is discarded.
  - acc <= 0 and the FSM returns to ACCUM.
  - A sample_valid arriving during EVAL is not lost: acc <= mic_in, cnt <= 1.
- Latency: level/peak/level_valid change on the first rising edge after the edge that accepted the WINDOW-th sample (1 clk).
- level_valid is 0 in all other cycles.
- Release floor: level never decrements below 0. With DECAY_EN=1, one quiet window after level 15 gives 14, not 0.
- Attack: any window whose new value is >= the current level sets level immediately.
- freeze toggling affects only EVAL cycles; no partial-window effects.
- Reset mid-window discards acc and cnt. The first window after reset is a full WINDOW samples counted from the first accepted sample.
- Back-to-back strobes every cycle are legal; the window still contains exactly WINDOW samples.
- cnt is ceil(log2(WINDOW)) bits wide and never exceeds WINDOW-1.

Test Plan:
(bench runs with WINDOW=8, BASE=2048, STEP_SHIFT=7)
- Reset: hold rst_n=0, then release. Expect level=0, peak=0, level_valid=0. Then 8 samples of 2048 → level_valid pulse 1 clk after the 8th strobe, level=0, peak=2048.
- Spike: 7×2048 plus one 4095 → level=15, peak=4095. Next window 8×2048 → level=14, peak=2048. With DECAY_EN=0 the same sequence gives level=0.
- Quantisation: windows peaking at 2049, 2176, 2303, 3968 → levels 0, 1, 1, 15 (each preceded by a 4095 window with DECAY_EN=0).
- Freeze: reach level=15, set freeze=1, run a window peaking at 2048. Expect no level_valid, level=15, peak=4095. Clear freeze, run a 2048 window → level=14.
- EVAL overlap: sample_valid held high continuously with mic_in=3000 for 24 cycles. Expect level_valid pulses every 8 cycles, no sample dropped (count strobes between pulses = 8), level=7.
- Mid-window reset: 5 samples of 4095, pulse rst_n low, then 8 samples of 2048. Expect level=0, peak=2048, with exactly one level_valid pulse after those 8 samples.

Source files
------------

// File: rtl/mic_level_meter.sv
// mic_level_meter: peak-over-window microphone level meter.
// Tracks the largest sample in each window of WINDOW accepted samples,
// quantises it to a 0..15 bar level with instant attack and optional
// one-step-per-window release, and exports the raw window peak.
module mic_level_meter #(
    parameter int          WINDOW     = 4000,
    parameter logic [11:0] BASE       = 12'd2048,
    parameter int          STEP_SHIFT = 7,
    parameter bit          DECAY_EN   = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sample_valid,
    input  logic [11:0] mic_in,
    input  logic        freeze,
    output logic [3:0]  level,
    output logic [11:0] peak,
    output logic        level_valid
);

    localparam int              CNT_W    = $clog2(WINDOW);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        ACCUM = 1'b0,
        EVAL  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [11:0]        acc_q, acc_d;
    logic [3:0]         level_q, level_d;
    logic [11:0]        peak_q, peak_d;
    logic               level_valid_q, level_valid_d;
    logic [3:0]         new_level;

    // Map a window peak to a bar level: zero at or below mid-scale,
    // otherwise the shifted excess saturated at 15.
    function automatic logic [3:0] quantise(input logic [11:0] pk);
        logic [11:0] excess;
        logic [11:0] steps;
        begin
            if (pk <= BASE) begin
                quantise = 4'd0;
            end else begin
                excess = pk - BASE;
                steps  = excess >> STEP_SHIFT;
                if (steps > 12'd15) begin
                    quantise = 4'd15;
                end else begin
                    quantise = steps[3:0];
                end
            end
        end
    endfunction

    assign new_level = quantise(acc_q);

    // Next-state logic: accumulate the window peak, then evaluate for one cycle.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        acc_d         = acc_q;
        level_d       = level_q;
        peak_d        = peak_q;
        level_valid_d = 1'b0;

        case (state_q)
            ACCUM: begin
                if (sample_valid) begin
                    acc_d = (mic_in > acc_q) ? mic_in : acc_q;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = EVAL;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            EVAL: begin
                if (!freeze) begin
                    peak_d        = acc_q;
                    level_valid_d = 1'b1;
                    // Attack is immediate; release drops one step per window.
                    // new_level < level_q here, so level_q is at least 1.
                    if (!DECAY_EN || (new_level >= level_q)) begin
                        level_d = new_level;
                    end else begin
                        level_d = level_q - 4'd1;
                    end
                end
                // A sample arriving now opens the next window rather than being lost.
                if (sample_valid) begin
                    acc_d = mic_in;
                    cnt_d = CNT_ONE;
                end else begin
                    acc_d = '0;
                    cnt_d = '0;
                end
                state_d = ACCUM;
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ACCUM;
            cnt_q         <= '0;
            acc_q         <= '0;
            level_q       <= '0;
            peak_q        <= '0;
            level_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            acc_q         <= acc_d;
            level_q       <= level_d;
            peak_q        <= peak_d;
            level_valid_q <= level_valid_d;
        end
    end

    assign level       = level_q;
    assign peak        = peak_q;
    assign level_valid = level_valid_q;

endmodule

// File: tb/tb_mic_level_meter.sv
// Self-checking bench for mic_level_meter: two instances (release limited
// and direct-follow) share one stimulus stream and are compared every cycle
// against a window-level behavioural model, plus literal scenario checks.
module tb_mic_level_meter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sample_valid = 1'b0;
    logic [11:0] mic_in = '0;
    logic        freeze = 1'b0;

    logic [3:0]  level0, level1;
    logic [11:0] peak0, peak1;
    logic        lv0, lv1;

    int checks = 0;
    int failures = 0;
    int npulse = 0;

    // Model state: index 0 = direct follow, index 1 = release limited.
    int  m_level [2];
    int  m_peak;
    int  m_vld;
    int  win_q [$];
    bit  pend;
    int  pend_max;

    always #5 clk = ~clk;

    mic_level_meter #(.WINDOW(8), .BASE(12'd2048), .STEP_SHIFT(7), .DECAY_EN(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .mic_in(mic_in),
        .freeze(freeze), .level(level0), .peak(peak0), .level_valid(lv0));

    mic_level_meter #(.WINDOW(8), .BASE(12'd2048), .STEP_SHIFT(7), .DECAY_EN(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .mic_in(mic_in),
        .freeze(freeze), .level(level1), .peak(peak1), .level_valid(lv1));

    function automatic int qlev(input int p);
        int s;
        if (p <= 2048) return 0;
        s = (p - 2048) / 128;
        return (s > 15) ? 15 : s;
    endfunction

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", nm, got, exp, $time);
        end
    endtask

    // Behavioural model: collect WINDOW samples, evaluate on the following edge.
    initial begin
        int nv, mx;
        m_level[0] = 0; m_level[1] = 0; m_peak = 0; m_vld = 0; pend = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_level[0] = 0; m_level[1] = 0; m_peak = 0; m_vld = 0;
                pend = 0; win_q.delete();
            end else begin
                m_vld = 0;
                if (pend) begin
                    pend = 0;
                    if (!freeze) begin
                        nv = qlev(pend_max);
                        m_peak = pend_max;
                        m_vld = 1;
                        m_level[0] = nv;
                        if (nv >= m_level[1]) m_level[1] = nv;
                        else m_level[1] = m_level[1] - 1;
                    end
                end
                if (sample_valid) begin
                    win_q.push_back(int'(mic_in));
                    if (win_q.size() == 8) begin
                        mx = 0;
                        foreach (win_q[i]) if (win_q[i] > mx) mx = win_q[i];
                        pend_max = mx;
                        pend = 1;
                        win_q.delete();
                    end
                end
            end
        end
    end

    // Cycle compare, sampled away from both clock edges.
    initial begin
        forever begin
            @(posedge clk);
            #3;
            chk("cyc_level0", int'(level0), m_level[0]);
            chk("cyc_level1", int'(level1), m_level[1]);
            chk("cyc_peak0", int'(peak0), m_peak);
            chk("cyc_peak1", int'(peak1), m_peak);
            chk("cyc_valid0", int'(lv0), m_vld);
            chk("cyc_valid1", int'(lv1), m_vld);
            if (lv1) npulse++;
        end
    end

    task automatic send(input logic [11:0] v, input int gap);
        @(negedge clk);
        sample_valid = 1'b1;
        mic_in = v;
        @(negedge clk);
        sample_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic win(input logic [11:0] pk, input logic [11:0] fill);
        int pos;
        pos = $urandom_range(0, 7);
        for (int i = 0; i < 8; i++) send((i == pos) ? pk : fill, $urandom_range(0, 1));
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int qv [4];
        int qe [4];
        qv = '{2049, 2176, 2303, 3968};
        qe = '{0, 1, 1, 15};

        // Reset
        repeat (3) @(negedge clk);
        chk("rst_level", int'(level1), 0);
        chk("rst_peak", int'(peak1), 0);
        chk("rst_valid", int'(lv1), 0);
        rst_n = 1'b1;
        win(12'd2048, 12'd2048);
        settle();
        chk("mid_level", int'(level0), 0);
        chk("mid_peak", int'(peak0), 2048);

        // Spike and release
        win(12'd4095, 12'd2048);
        settle();
        chk("spike_level_decay", int'(level1), 15);
        chk("spike_level_direct", int'(level0), 15);
        chk("spike_peak", int'(peak1), 4095);
        win(12'd2048, 12'd2048);
        settle();
        chk("release_level_decay", int'(level1), 14);
        chk("release_level_direct", int'(level0), 0);
        chk("release_peak", int'(peak1), 2048);

        // Quantisation
        for (int i = 0; i < 4; i++) begin
            win(12'd4095, 12'd2048);
            win(12'(qv[i]), 12'd2048);
            settle();
            chk($sformatf("quant_%0d", qv[i]), int'(level0), qe[i]);
        end

        // Freeze
        win(12'd4095, 12'd2048);
        settle();
        chk("pre_freeze_level", int'(level1), 15);
        freeze = 1'b1;
        npulse = 0;
        win(12'd2048, 12'd2048);
        settle();
        chk("freeze_pulses", npulse, 0);
        chk("freeze_level", int'(level1), 15);
        chk("freeze_peak", int'(peak1), 4095);
        freeze = 1'b0;
        win(12'd2048, 12'd2048);
        settle();
        chk("unfreeze_level", int'(level1), 14);

        // Continuous strobes across EVAL cycles
        npulse = 0;
        @(negedge clk);
        sample_valid = 1'b1;
        mic_in = 12'd3000;
        repeat (24) @(negedge clk);
        sample_valid = 1'b0;
        settle();
        chk("overlap_pulses", npulse, 3);
        chk("overlap_level", int'(level0), 7);
        chk("overlap_peak", int'(peak0), 3000);

        // Reset mid-window
        for (int i = 0; i < 5; i++) send(12'd4095, 0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        npulse = 0;
        for (int i = 0; i < 8; i++) send(12'd2048, $urandom_range(0, 1));
        settle();
        chk("rstmid_level0", int'(level0), 0);
        chk("rstmid_level1", int'(level1), 0);
        chk("rstmid_peak", int'(peak1), 2048);
        chk("rstmid_pulses", npulse, 1);

        // Random windows with random freeze
        for (int w = 0; w < 30; w++) begin
            freeze = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < 8; i++) send(12'($urandom_range(0, 4095)), $urandom_range(0, 2));
            settle();
        end
        freeze = 1'b0;
        settle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
